// File: rtl/bp_access_scheduler_pkg.sv
// Shared types for the branch-predictor access scheduler: resource commands,
// scheduler states and the buffered update entry.
package bp_access_scheduler_pkg;

  localparam int DEF_PC_BITS   = 10;
  localparam int DEF_HIST_BITS = 10;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'd0,
    CMD_LHT_RD  = 2'd1,
    CMD_PRED_RD = 2'd2,
    CMD_UPDATE  = 2'd3
  } res_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LK_LHT,
    S_LK_PRED,
    S_LK_RESP,
    S_UPD
  } sched_state_e;

  typedef struct packed {
    logic [DEF_PC_BITS-1:0] pc;
    logic                   taken;
  } upd_entry_t;

endpackage

// File: rtl/bp_access_scheduler_if.sv
// Fetch/retire/resource signal bundle of the access scheduler. The master
// modport is the scheduler; the slave modport is the surrounding logic.
interface bp_access_scheduler_if #(
  parameter int PC_BITS   = 10,
  parameter int HIST_BITS = 10,
  parameter int UPD_DEPTH = 4
);
  localparam int CNT_W = $clog2(UPD_DEPTH) + 1;

  logic                 lk_valid;
  logic [PC_BITS-1:0]   lk_pc;
  logic                 lk_ready;
  logic                 pred_valid;
  logic                 pred_taken;
  logic                 upd_valid;
  logic [PC_BITS-1:0]   upd_pc;
  logic                 upd_taken;
  logic                 upd_ready;
  logic [CNT_W-1:0]     upd_count;
  logic [1:0]           res_cmd;
  logic [PC_BITS-1:0]   res_addr;
  logic [HIST_BITS-1:0] res_hist;
  logic                 res_taken;
  logic [HIST_BITS-1:0] res_rdata;
  logic                 res_pred;

  modport master (
    input  lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, res_rdata, res_pred,
    output lk_ready, pred_valid, pred_taken, upd_ready, upd_count,
           res_cmd, res_addr, res_hist, res_taken
  );

  modport slave (
    output lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, res_rdata, res_pred,
    input  lk_ready, pred_valid, pred_taken, upd_ready, upd_count,
           res_cmd, res_addr, res_hist, res_taken
  );
endinterface

// File: rtl/bp_access_scheduler_upd_fifo.sv
// Small power-of-two FIFO holding retired-branch updates until the shared
// predictor resource is granted to the update path.
module bp_access_scheduler_upd_fifo
  import bp_access_scheduler_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = upd_entry_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/bp_access_scheduler.sv
// Arbitrates the single-ported LHT/predictor resource between fetch lookups
// (LHT read, then prediction read) and buffered retire-side updates.
module bp_access_scheduler
  import bp_access_scheduler_pkg::*;
#(
  parameter int PC_BITS    = DEF_PC_BITS,
  parameter int HIST_BITS  = DEF_HIST_BITS,
  parameter int UPD_DEPTH  = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  bp_access_scheduler_if.master  bus
);
  localparam int CNT_W = $clog2(UPD_DEPTH) + 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [PC_BITS-1:0] pc;
    logic               taken;
  } entry_t;

  sched_state_e         state_q;
  logic [PC_BITS-1:0]   pc_q;
  logic [SW-1:0]        starve_q;
  logic                 pred_valid_q;
  logic                 pred_taken_q;

  entry_t               fifo_din;
  entry_t               fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;

  logic                 in_idle;
  logic                 upd_first;
  logic                 lk_grant;
  logic                 upd_grant;
  logic                 upd_ready;

  res_cmd_e             res_cmd;
  logic [PC_BITS-1:0]   res_addr;
  logic [HIST_BITS-1:0] res_hist;
  logic                 res_taken;

  // Updates pre-empt lookups when the FIFO is full or lookups have starved it.
  assign in_idle   = (state_q == S_IDLE) && !reset;
  assign upd_first = fifo_full || (!fifo_empty && (starve_q == SW'(STARVE_MAX)));
  assign lk_grant  = in_idle && !upd_first && bus.lk_valid;
  assign upd_grant = in_idle && (upd_first || (!bus.lk_valid && !fifo_empty));
  assign upd_ready = !reset && !fifo_full;

  assign fifo_push = bus.upd_valid && upd_ready;
  assign fifo_pop  = (state_q == S_UPD);
  assign fifo_din  = '{pc: bus.upd_pc, taken: bus.upd_taken};

  bp_access_scheduler_upd_fifo #(
    .DEPTH   (UPD_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      starve_q     <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      pred_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (lk_grant)       state_q <= S_LK_LHT;
          else if (upd_grant) state_q <= S_UPD;
        end
        S_LK_LHT:  state_q <= S_LK_PRED;
        S_LK_PRED: state_q <= S_LK_RESP;
        S_LK_RESP: begin
          pred_valid_q <= 1'b1;
          pred_taken_q <= bus.res_pred;
          state_q      <= S_IDLE;
        end
        S_UPD:     state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
      if (upd_grant || fifo_empty)
        starve_q <= '0;
      else if (lk_grant && (starve_q != SW'(STARVE_MAX)))
        starve_q <= starve_q + SW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (lk_grant) pc_q <= bus.lk_pc;
  end

  always_comb begin
    res_cmd   = CMD_NOP;
    res_addr  = '0;
    res_hist  = '0;
    res_taken = 1'b0;
    if (!reset) begin
      case (state_q)
        S_LK_LHT: begin
          res_cmd  = CMD_LHT_RD;
          res_addr = pc_q;
        end
        S_LK_PRED: begin
          res_cmd  = CMD_PRED_RD;
          res_addr = pc_q;
          res_hist = bus.res_rdata;
        end
        S_UPD: begin
          res_cmd   = CMD_UPDATE;
          res_addr  = fifo_head.pc;
          res_taken = fifo_head.taken;
        end
        default: ;
      endcase
    end
  end

  assign bus.lk_ready   = lk_grant;
  assign bus.upd_ready  = upd_ready;
  assign bus.upd_count  = fifo_count;
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.res_cmd    = res_cmd;
  assign bus.res_addr   = res_addr;
  assign bus.res_hist   = res_hist;
  assign bus.res_taken  = res_taken;

endmodule
